// File: rtl/mips_muldiv.sv
// mips_muldiv: 32-cycle shift-add multiply / restoring divide feeding the register-file LO writeback.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU finish immediately with zero results.
module mips_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [2:0]  dest_reg,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] write_data,
  output logic [2:0]  write_reg,
  output logic        signal_reg_write
);
  localparam int unsigned DataW = 32;
  localparam int unsigned AccW  = 2 * DataW;
  localparam int unsigned RegW  = 3;
  localparam int unsigned CntW  = 5;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [RegW-1:0]   dest_q, dest_d;
  logic [DataW-1:0]  mcand_q, mcand_d;   // multiplicand (mult) or divisor (div) magnitude
  logic [1:0]        sign_q, sign_d;     // {operand_a negative, operand_b negative}
  logic [AccW-1:0]   acc_q, acc_d;
  logic [DataW-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              busy_q, busy_d, done_q, done_d, wen_q, wen_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [RegW-1:0]   wreg_q, wreg_d;

  logic              a_neg, b_neg;
  logic [DataW-1:0]  mag_a, mag_b;
  logic [DataW:0]    mul_sum;
  logic [AccW-1:0]   mul_step, mul_res, div_step;
  logic [DataW-1:0]  div_hi, div_lo, res_hi, res_lo;

  // Operand magnitudes; -2^31 maps to the unsigned value 32'h80000000.
  assign a_neg = ~op[0] & operand_a[DataW-1];
  assign b_neg = ~op[0] & operand_b[DataW-1];
  assign mag_a = a_neg ? -operand_a : operand_a;
  assign mag_b = b_neg ? -operand_b : operand_b;

  // Shift-add: multiplier sits in acc low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[AccW-1:DataW]} + ({1'b0, mcand_q} & {(DataW+1){acc_q[0]}});
  assign mul_step = {mul_sum, acc_q[DataW-1:1]};
  assign mul_res  = (^sign_q) ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic [DataW:0]   div_sh;
  logic             div_ge;
  logic [DataW-1:0] div_rem, div_q, div_r;

  // Restoring step: acc = {remainder, dividend/quotient}, 33-bit trial remainder.
  assign div_sh   = {acc_q[AccW-1:DataW], acc_q[DataW-1]};
  assign div_ge   = div_sh >= {1'b0, mcand_q};
  assign div_rem  = div_ge ? (div_sh[DataW-1:0] - mcand_q) : div_sh[DataW-1:0];
  assign div_step = {div_rem, acc_q[DataW-2:0], div_ge};
  assign div_q    = acc_q[DataW-1:0];
  assign div_r    = acc_q[AccW-1:DataW];

  // A zero divisor leaves remainder = |dividend|, so the signed remainder is the original operand_a.
  always_comb begin
    div_lo = (^sign_q) ? -div_q : div_q;
    div_hi = sign_q[1] ? -div_r : div_r;
    if (mcand_q == '0) begin
      div_lo = '1;
    end else if (sign_q == 2'b11 && mcand_q == DataW'(1) && div_q == 32'h8000_0000) begin
      div_lo = 32'h8000_0000;
      div_hi = '0;
    end
  end
`else
  assign div_step = '0;
  assign div_lo   = '0;
  assign div_hi   = '0;
`endif

  assign res_hi = is_div_q ? div_hi : mul_res[AccW-1:DataW];
  assign res_lo = is_div_q ? div_lo : mul_res[DataW-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    dest_d   = dest_q;
    mcand_d  = mcand_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wen_d    = 1'b0;
    wdata_d  = '0;
    wreg_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          dest_d   = dest_reg;
          sign_d   = {a_neg, b_neg};
          mcand_d  = op[1] ? mag_b : mag_a;
          acc_d    = {DataW'(0), (op[1] ? mag_a : mag_b)};
          cnt_d    = '0;
          if (op[1] && !DivEn) begin
            state_d = S_DONE;
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b1;
            wreg_d  = dest_reg;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(31)) state_d = S_SIGN;
      end
      S_SIGN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        hi_d    = res_hi;
        lo_d    = res_lo;
        wdata_d = res_lo;
        wreg_d  = dest_q;
        wen_d   = dest_q != '0;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dest_q   <= '0;
      mcand_q  <= '0;
      sign_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wreg_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      dest_q   <= dest_d;
      mcand_q  <= mcand_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wreg_q   <= wreg_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign hi               = hi_q;
  assign lo               = lo_q;
  assign write_data       = wdata_q;
  assign write_reg        = wreg_q;
  assign signal_reg_write = wen_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv; expectations follow MULDIV_DIV_EN the same way the DUT does.
module tb_mips_muldiv;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic [2:0]  dest_reg;
  logic        busy, done, signal_reg_write;
  logic [31:0] hi, lo, write_data;
  logic [2:0]  write_reg;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wen;
    logic [2:0]  wreg;
    int          lat;
    bit          busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mips_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .write_data(write_data), .write_reg(write_reg), .signal_reg_write(signal_reg_write)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] d);
    exp_t                e;
    longint              sp;
    longint unsigned     up;
    e.lat  = 33;
    e.busy = 1'b1;
    e.wreg = d;
    e.hi   = '0;
    e.lo   = '0;
    case (o)
      2'b00: begin
        sp   = longint'($signed(a)) * longint'($signed(b));
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end
      2'b01: begin
        up   = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
`ifdef MULDIV_DIV_EN
      2'b10: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else begin
          e.lo = 32'($signed(a) / $signed(b));
          e.hi = 32'($signed(a) % $signed(b));
        end
      end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
`else
      default: begin
        e.lat  = 0;
        e.busy = 1'b0;
      end
`endif
    endcase
    e.wen = e.busy && (d != 3'd0);
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] d, input bit track);
    if (track) exp_q.push_back(model(o, a, b, d));
    op = o; operand_a = a; operand_b = b; dest_reg = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    dest_reg = 3'($urandom); op = 2'($urandom);
  endtask

  task automatic wait_done(output int k, output bit bs);
    k  = 0;
    bs = 1'b0;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) bs = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    if (done !== 1'b1) k = -1;
  endtask

  task automatic check_completion(input string name, input int k, input bit bs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL %s scoreboard: got empty queue want one entry", name);
      return;
    end
    e = exp_q.pop_front();
    total++; if (k !== e.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, k, e.lat); end
    total++; if (bs !== e.busy) begin bad++; $display("FAIL %s busy_seen: got %0b want %0b", name, bs, e.busy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %0b want 0", name, busy); end
    total++; if (hi !== e.hi) begin bad++; $display("FAIL %s hi: got %h want %h", name, hi, e.hi); end
    total++; if (lo !== e.lo) begin bad++; $display("FAIL %s lo: got %h want %h", name, lo, e.lo); end
    total++; if (signal_reg_write !== e.wen) begin bad++; $display("FAIL %s wen: got %0b want %0b", name, signal_reg_write, e.wen); end
    total++; if (write_data !== e.lo) begin bad++; $display("FAIL %s wdata: got %h want %h", name, write_data, e.lo); end
    if (e.wen) begin
      total++; if (write_reg !== e.wreg) begin bad++; $display("FAIL %s wreg: got %0d want %0d", name, write_reg, e.wreg); end
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || signal_reg_write !== 1'b0) begin
      bad++; $display("FAIL %s pulse_end: got done=%0b wen=%0b want 0/0", name, done, signal_reg_write);
    end
    total++; if (write_data !== 32'd0 || write_reg !== 3'd0) begin
      bad++; $display("FAIL %s wport_idle: got %h/%0d want 0/0", name, write_data, write_reg);
    end
    total++; if (hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL %s hold: got %h_%h want %h_%h", name, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] d);
    int k; bit bs;
    issue(o, a, b, d, 1'b1);
    wait_done(k, bs);
    check_completion(name, k, bs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_ctl: got busy=%0b done=%0b want 0/0", busy, done); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo); end
    total++; if (write_data !== 32'd0 || write_reg !== 3'd0 || signal_reg_write !== 1'b0) begin
      bad++; $display("FAIL reset_wport: got %h/%0d/%0b want 0", write_data, write_reg, signal_reg_write);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int k; bit bs;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b1);
    wait_done(k, bs);
    total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || write_reg !== 3'd3) begin
      bad++; $display("FAIL multu_const: got %h_%h r%0d want fffffffe_00000001 r3", hi, lo, write_reg);
    end
    check_completion("multu_max", k, bs);
  endtask

  task automatic test_mult();
    int k; bit bs;
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 3'd0, 1'b1);
    wait_done(k, bs);
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || signal_reg_write !== 1'b0) begin
      bad++; $display("FAIL mult_const: got %h_%h wen=%0b want ffffffff_ffffffeb wen=0", hi, lo, signal_reg_write);
    end
    check_completion("mult_neg_dest0", k, bs);
    do_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 3'd6);
  endtask

  task automatic test_div();
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 3'd5);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 3'd1);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0, 3'd2);
    do_op("div_zero_neg", 2'b10, 32'hFFFF_FFF7, 32'd0, 3'd4);
    do_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd7, 3'd7);
  endtask

  task automatic test_ignored_start();
    int k; bit bs, seen;
    issue(2'b01, 32'd2, 32'd3, 3'd6, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    op = 2'b01; operand_a = 32'd9; operand_b = 32'd9; dest_reg = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(k, bs);
    total++; if (lo !== 32'd6 || hi !== 32'd0) begin bad++; $display("FAIL ignored_run: got %h_%h want 0_6", hi, lo); end
    op = 2'b00; operand_a = 32'd7; operand_b = 32'd7; dest_reg = 3'd1; start = 1'b1;
    check_completion("ignored_start", k + 6, bs);
    start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1 || signal_reg_write === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ignored_done: got extra activity=1 want 0"); end
  endtask

  task automatic test_back_to_back();
    do_op("b2b_0", 2'b01, 32'd123456, 32'd654321, 3'd1);
    do_op("b2b_1", 2'b00, 32'hFFFF_0000, 32'h0001_0000, 3'd2);
    do_op("b2b_2", 2'b10, 32'd1000, 32'hFFFF_FFFD, 3'd3);
    do_op("b2b_3", 2'b01, 32'd5, 32'd6, 3'd4);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      do_op($sformatf("rand%0d", i), 2'($urandom), a, b, 3'($urandom));
    end
  endtask

  task automatic test_reset_midrun();
    bit seen;
    do_op("pre_reset", 2'b01, 32'd5, 32'd6, 3'd5);
    issue(2'b01, 32'd5, 32'd6, 3'd3, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrun_ctl: got busy=%0b done=%0b want 0/0", busy, done); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL midrun_hilo: got %h_%h want 0", hi, lo); end
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done === 1'b1 || signal_reg_write === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrun_pulse: got pulse=1 want 0"); end
    do_op("post_reset", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 3'd7);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
